serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that feeds the team's 1-bit decoder-based full-adder stage and consumes its sum/carry outputs.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse.
- Presents one bit pair per cycle, LSB first, with the registered running carry, on fa_in.
- Shifts the returned fa_sum into a result register and feeds fa_carry back as the next carry.
- Signals completion with a one-cycle done pulse.

---
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Purpose : Bit-serial adder controller driving an external 1-bit full adder.
// Revision: 1.0
// ============================================================================

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [2:0]       fa_in,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               c_q, c_d;
    logic [WIDTH-2:0]   sum_sh_q, sum_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   w_sum_next;

    // Only the upper WIDTH-1 partial-sum bits are stored; the LSB slot would
    // be shifted out on the same edge it is filled.
    assign w_sum_next = {fa_sum, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        c_d      = c_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        fa_in    = 3'b000;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    c_d      = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                fa_in    = {a_sh_q[0], b_sh_q[0], c_q};
                sum_sh_d = w_sum_next[WIDTH-1:1];
                c_d      = fa_carry;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    sum_d   = w_sum_next;
                    cout_d  = fa_carry;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            c_q      <= 1'b0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            c_q      <= c_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Purpose : Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=16).
// Revision: 1.0
// ============================================================================

module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  fa_in8;
    logic        fa_sum8, fa_carry8, busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  fa_in16;
    logic        fa_sum16, fa_carry16, busy16, done16, cout16;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural full adder stages
    assign fa_sum8    = ^fa_in8;
    assign fa_carry8  = (fa_in8[2] & fa_in8[1]) | (fa_in8[2] & fa_in8[0]) | (fa_in8[1] & fa_in8[0]);
    assign fa_sum16   = ^fa_in16;
    assign fa_carry16 = (fa_in16[2] & fa_in16[1]) | (fa_in16[2] & fa_in16[0]) | (fa_in16[1] & fa_in16[0]);

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_in(fa_in8), .fa_sum(fa_sum8), .fa_carry(fa_carry8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .fa_in(fa_in16), .fa_sum(fa_sum16), .fa_carry(fa_carry16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input logic [7:0] es, input logic eco, input bit full);
        int n, nb;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1; nb = 0;
        while (!done8 && n < 60) begin
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
        if (full) begin
            chk("latency8", n, 9);
            chk("busy_cycles8", nb, 8);
        end else if (!done8) begin
            chk("timeout8", 0, 1);
        end
        chk("sum8", {24'd0, sum8}, {24'd0, es});
        chk("cout8", {31'd0, cout8}, {31'd0, eco});
        @(negedge clk);
    endtask

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                            input logic [15:0] es, input logic eco);
        int n;
        @(negedge clk);
        a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("latency16", n, 17);
        chk("sum16", {16'd0, sum16}, {16'd0, es});
        chk("cout16", {31'd0, cout16}, {31'd0, eco});
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  fexp[8];
        logic [7:0]  prev_sum;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [8:0]  e9;
        logic [15:0] ra16, rb16;
        logic        rc16;
        logic [16:0] e17;
        int          n, nd, nbusy;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'h03, 8'h01, 1'b0, 8'h04, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        fexp = '{3'b110, 3'b101, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_sum", {24'd0, sum8}, 0);
        chk("rst_cout", {31'd0, cout8}, 0);
        chk("rst_fa_in", {29'd0, fa_in8}, 0);
        chk("rst_sum16", {16'd0, sum16}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy8}, 0);

        for (int i = 0; i < 8; i++)
            run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, 1'b1);

        // fa_in trace for 3 + 1
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fa_in_cyc%0d", i + 1), {29'd0, fa_in8}, {29'd0, fexp[i]});
            @(negedge clk);
        end
        chk("fa_trace_done", {31'd0, done8}, 1);
        chk("fa_trace_fa_in_done", {29'd0, fa_in8}, 0);
        chk("fa_trace_sum", {24'd0, sum8}, 32'h04);
        @(negedge clk);

        // start held high, operands changed mid-run
        prev_sum = 8'h04;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        chk("hold_busy", {31'd0, busy8}, 1);
        chk("hold_sum_kept", {24'd0, sum8}, {24'd0, prev_sum});
        n = 1;
        while (!done8 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hold_latency", n, 9);
        chk("hold_sum", {24'd0, sum8}, 32'h33);
        chk("hold_cout", {31'd0, cout8}, 0);
        @(negedge clk);
        chk("hold_idle_busy", {31'd0, busy8}, 0);
        chk("hold_idle_done", {31'd0, done8}, 0);
        @(negedge clk);
        chk("hold_restart_busy", {31'd0, busy8}, 1);
        chk("hold_restart_sum_kept", {24'd0, sum8}, 32'h33);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hold2_latency", n, 9);
        chk("hold2_sum", {24'd0, sum8}, 32'hFF);
        chk("hold2_cout", {31'd0, cout8}, 1);
        @(negedge clk);

        // Reset mid-run
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy8}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy8}, 0);
        chk("abort_done", {31'd0, done8}, 0);
        chk("abort_sum", {24'd0, sum8}, 0);
        chk("abort_cout", {31'd0, cout8}, 0);
        chk("abort_fa_in", {29'd0, fa_in8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0; nbusy = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
            if (busy8) nbusy++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_no_busy", nbusy, 0);
        run_op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);

        // Randomised operations on both widths
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ra16 = 16'($urandom); rb16 = 16'($urandom); rc16 = 1'($urandom);
            e9  = 9'(ra) + 9'(rb) + 9'(rc);
            e17 = 17'(ra16) + 17'(rb16) + 17'(rc16);
            fork
                run_op8(ra, rb, rc, e9[7:0], e9[8], 1'b0);
                run_op16(ra16, rb16, rc16, e17[15:0], e17[16]);
            join
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
